// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART TX stream.
// The grant is held for a whole tlast-delimited frame, optionally followed by an idle gap.
module uart_tx_arbiter #(
   parameter  int DATA_WIDTH = 8,
   parameter  int PORTS      = 4,
   parameter  int GAP_CYCLES = 0,
   localparam int IDX_W      = $clog2(PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [PORTS-1:0]            s_axis_tvalid,
   input  logic [PORTS-1:0]            s_axis_tlast,
   output logic [PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        grant_valid,
   output logic [IDX_W-1:0]            grant_index,
   output logic                        busy
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   state_t           state;
   logic [IDX_W-1:0] last;
   logic [CNT_W-1:0] gap_cnt;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic             last_beat;
   int               p;

   // Search upward from the port after the previous winner, wrapping modulo PORTS.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      p         = 0;
      for (int k = 1; k <= PORTS; k++) begin
         p = (int'(last) + k) % PORTS;
         if (!win_found && s_axis_tvalid[p]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(p);
         end
      end
   end

   // Pass-through only while a frame is granted; everything is forced to 0 otherwise.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      if (state == S_XFER) begin
         m_axis_tdata               = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid              = s_axis_tvalid[grant_index];
         s_axis_tready[grant_index] = m_axis_tready;
      end
   end

   assign last_beat = m_axis_tvalid && m_axis_tready && s_axis_tlast[grant_index];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         grant_valid <= 1'b0;
         grant_index <= '0;
         busy        <= 1'b0;
         last        <= IDX_W'(PORTS - 1);
         gap_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  state       <= S_XFER;
                  grant_index <= win_idx;
                  last        <= win_idx;
                  grant_valid <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_XFER: begin
               if (last_beat) begin
                  grant_valid <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= S_GAP;
                     gap_cnt <= GAP_LOAD;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               grant_valid <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one instance without gap, one with a 5-cycle gap,
// both fed from the same requester stimulus; sel picks which one the monitor watches.
module tb_uart_tx_arbiter;

   localparam int DW = 8;
   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [DW-1:0]    td [NP];
   logic [NP*DW-1:0] s_tdata;
   logic [NP-1:0]    s_tvalid = '0;
   logic [NP-1:0]    s_tlast  = '0;
   logic             m_tready = 1'b0;
   logic             sel      = 1'b0;

   logic [NP-1:0] r0, r5;
   logic [DW-1:0] d0, d5;
   logic          v0, v5, gv0, gv5, b0, b5;
   logic [1:0]    gi0, gi5;

   logic [NP-1:0] mrdy;
   logic [DW-1:0] md;
   logic          mv, mgv, mb;
   logic [1:0]    mgi;

   typedef struct {int port; logic [DW-1:0] data;} exp_t;
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < NP; i++) s_tdata[i*DW +: DW] = td[i];

   assign mrdy = sel ? r5  : r0;
   assign md   = sel ? d5  : d0;
   assign mv   = sel ? v5  : v0;
   assign mgv  = sel ? gv5 : gv0;
   assign mgi  = sel ? gi5 : gi0;
   assign mb   = sel ? b5  : b0;

   uart_tx_arbiter #(.DATA_WIDTH(DW), .PORTS(NP), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tready(r0), .m_axis_tdata(d0), .m_axis_tvalid(v0),
      .m_axis_tready(m_tready), .grant_valid(gv0), .grant_index(gi0), .busy(b0));

   uart_tx_arbiter #(.DATA_WIDTH(DW), .PORTS(NP), .GAP_CYCLES(5)) dut5 (
      .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tready(r5), .m_axis_tdata(d5), .m_axis_tvalid(v5),
      .m_axis_tready(m_tready), .grant_valid(gv5), .grant_index(gi5), .busy(b5));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int port, input logic [DW-1:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mv && m_tready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", int'(md), -1);
            end else begin
               e = sb.pop_front();
               chk("beat_port", int'(mgi), e.port);
               chk("beat_data", int'(md), int'(e.data));
               chk("beat_ready_onehot", int'(mrdy), 1 << e.port);
            end
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b0;
      m_tready = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int i = 0; i < NP; i++) td[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Drive one frame on port p; optionally drop tvalid for drop_len cycles before beat drop_at.
   task automatic send_frame(input int p, input int n, input logic [DW-1:0] base,
                             input int drop_at, input int drop_len);
      int t;
      for (int k = 0; k < n; k++) begin
         if (k == drop_at && drop_len > 0) begin
            s_tvalid[p] = 1'b0;
            repeat (drop_len) begin
               @(negedge clk);
               chk("hold_grant_index", int'(mgi), p);
               chk("hold_grant_valid", int'(mgv), 1);
               chk("hold_other_ready", int'(mrdy & ~(NP'(1) << p)), 0);
            end
            @(posedge clk);
            #1;
         end
         s_tvalid[p] = 1'b1;
         td[p]       = base + DW'(k);
         s_tlast[p]  = (k == n - 1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!mrdy[p] && t < 300);
         chk("handshake_timeout", int'(mrdy[p]), 1);
         @(posedge clk);
         #1;
      end
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(name, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int n;
      for (int i = 0; i < NP; i++) td[i] = '0;

      // Reset state on both instances
      do_reset();
      rst = 1'b0;
      #1;
      chk("rst_gv0", int'(gv0), 0);   chk("rst_gi0", int'(gi0), 0);
      chk("rst_busy0", int'(b0), 0);  chk("rst_v0", int'(v0), 0);
      chk("rst_rdy0", int'(r0), 0);   chk("rst_data0", int'(d0), 0);
      chk("rst_gv5", int'(gv5), 0);   chk("rst_busy5", int'(b5), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Test 1: port 2 sends 0x41,0x42,0x43 with ready held high
      sel = 1'b0;
      m_tready = 1'b1;
      push(2, 8'h41); push(2, 8'h42); push(2, 8'h43);
      @(posedge clk); #1;
      s_tvalid[2] = 1'b1; td[2] = 8'h41;
      @(negedge clk);
      chk("t1_pre_grant", int'(gv0), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_grant_valid", int'(gv0), 1);
      chk("t1_grant_index", int'(gi0), 2);
      chk("t1_busy", int'(b0), 1);
      @(posedge clk); #1 td[2] = 8'h42;
      @(posedge clk); #1 td[2] = 8'h43; s_tlast[2] = 1'b1;
      @(posedge clk); #1 s_tvalid[2] = 1'b0; s_tlast[2] = 1'b0;
      @(negedge clk);
      chk("t1_idle_busy", int'(b0), 0);
      chk("t1_idle_gv", int'(gv0), 0);
      chk("t1_idle_data", int'(d0), 0);
      chk("t1_gi_hold", int'(gi0), 2);
      drain("t1_drain");

      // Test 2: all ports continuously valid, single-beat frames
      do_reset();
      m_tready = 1'b1;
      push(0, 8'h00); push(1, 8'h10); push(2, 8'h20); push(3, 8'h30);
      push(0, 8'h01); push(1, 8'h11);
      fork
         begin send_frame(0, 1, 8'h00, -1, 0); send_frame(0, 1, 8'h01, -1, 0); end
         begin send_frame(1, 1, 8'h10, -1, 0); send_frame(1, 1, 8'h11, -1, 0); end
         send_frame(2, 1, 8'h20, -1, 0);
         send_frame(3, 1, 8'h30, -1, 0);
      join
      drain("t2_drain");

      // Test 3: port 0 4-beat frame under a 1,0,0 ready pattern while port 1 waits
      do_reset();
      push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
      push(1, 8'hB0); push(1, 8'hB1);
      fork
         send_frame(0, 4, 8'hA0, -1, 0);
         send_frame(1, 2, 8'hB0, -1, 0);
         for (int i = 0; i < 60; i++) begin
            m_tready = (i % 3 == 0);
            @(posedge clk);
            #1;
         end
      join
      drain("t3_drain");

      // Test 4: 5-cycle gap instance, port 1 sends two frames back to back
      do_reset();
      sel = 1'b1;
      m_tready = 1'b1;
      push(1, 8'h50); push(1, 8'h51); push(1, 8'h60); push(1, 8'h61);
      fork
         begin send_frame(1, 2, 8'h50, -1, 0); send_frame(1, 2, 8'h60, -1, 0); end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(v5 && m_tready && s_tlast[1]) && n < 100);
            chk("t4_first_tlast_seen", int'(v5 && s_tlast[1]), 1);
            @(negedge clk);
            n = 0;
            while (b5 && !v5 && n < 50) begin
               chk("t4_gap_gv", int'(gv5), 0);
               n++;
               @(negedge clk);
            end
            chk("t4_gap_len", n, 5);
            chk("t4_idle_busy", int'(b5), 0);
            @(negedge clk);
            chk("t4_regrant_gv", int'(gv5), 1);
            chk("t4_regrant_gi", int'(gi5), 1);
         end
      join
      drain("t4_drain");
      sel = 1'b0;

      // Test 5: reset pulse in the middle of a port-3 frame
      do_reset();
      m_tready = 1'b1;
      push(3, 8'hC0); push(3, 8'hC1);
      s_tvalid[3] = 1'b1; td[3] = 8'hC0;
      @(posedge clk); #1;
      @(posedge clk); #1 td[3] = 8'hC1;
      @(posedge clk); #1 td[3] = 8'hC2;
      #1 rst = 1'b0;
      #1;
      chk("t5_async_v", int'(v0), 0);
      chk("t5_async_rdy", int'(r0), 0);
      chk("t5_async_data", int'(d0), 0);
      chk("t5_async_gv", int'(gv0), 0);
      chk("t5_async_gi", int'(gi0), 0);
      chk("t5_async_busy", int'(b0), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      m_tready = 1'b0;
      s_tvalid[0] = 1'b1; td[0] = 8'hD0;
      @(negedge clk);
      chk("t5_release_idle", int'(gv0), 0);
      @(negedge clk);
      chk("t5_contention_gv", int'(gv0), 1);
      chk("t5_contention_gi", int'(gi0), 0);
      drain("t5_drain");

      // Test 6: port 1 stalls 10 cycles mid-frame while port 2 is valid
      do_reset();
      m_tready = 1'b1;
      push(1, 8'hE0); push(1, 8'hE1); push(1, 8'hE2); push(1, 8'hE3);
      push(2, 8'hF0); push(2, 8'hF1);
      fork
         send_frame(1, 4, 8'hE0, 2, 10);
         send_frame(2, 2, 8'hF0, -1, 0);
      join
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
